// File: rtl/simon_pad.sv
`default_nettype none
// ============================================================================
// Module   : simon_pad
// Purpose  : Player-side panel controller for the Simon game core. Turns four
//            raw push-buttons into playerNum/playerPressed (synchronise,
//            debounce, single-button arbitration, gating on simonTurn and
//            gameOver) and drives the four panel LEDs.
// Options  : SIMON_PAD_GAMEOVER_BLINK_EN - blink all LEDs while locked
//            (half-period BLINK_HALF cycles); otherwise steady all-on.
// Revision : 1.0 - initial release
// ============================================================================
module simon_pad #(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int BLINK_HALF      = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       simonTurn,
  input  logic [1:0] simonNum,
  input  logic       simonPressed,
  input  logic       gameOver,
  output logic [1:0] playerNum,
  output logic       playerPressed,
  output logic [3:0] led
);

  localparam logic [3:0] C_DB_LAST = 4'(DEBOUNCE_CYCLES - 1);
  // Cycles for a held button to propagate through sync + debounce.
  localparam logic [4:0] C_SETTLE  = 5'(DEBOUNCE_CYCLES + 2);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESSED  = 2'd1,
    WAIT_REL = 2'd2,
    LOCKED   = 2'd3
  } padState_t;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_badDebounce
    $error("simon_pad: DEBOUNCE_CYCLES must be 1..15");
  end
  if (BLINK_HALF < 1 || BLINK_HALF > 31) begin : g_badBlink
    $error("simon_pad: BLINK_HALF must be 1..31");
  end

  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_db;
  logic [4:0] r_settleCnt;
  logic       w_settled;
  logic       w_oneHot;
  logic [1:0] w_idx;
  padState_t  r_state;
  padState_t  w_nextState;
  logic [1:0] r_playerNum;
  logic [1:0] w_nextNum;
  logic       r_pressed;
  logic       w_nextPressed;
  logic [3:0] r_led;

  // Two-flop synchroniser for the raw buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_debounce
    logic       r_dbBit;
    logic [3:0] r_cnt;

    // Level changes only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_dbBit <= 1'b0;
        r_cnt   <= 4'd0;
      end else if (r_sync2[gi] == r_dbBit) begin
        r_cnt   <= 4'd0;
      end else if (r_cnt == C_DB_LAST) begin
        r_dbBit <= r_sync2[gi];
        r_cnt   <= 4'd0;
      end else begin
        r_cnt   <= r_cnt + 4'd1;
      end
    end

    assign w_db[gi] = r_dbBit;
  end

  // After reset the debounced levels read 0 even if a button is held; block
  // the WAIT_REL exit until a held button has had time to show up in w_db.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_settleCnt <= 5'd0;
    end else if (r_settleCnt != C_SETTLE) begin
      r_settleCnt <= r_settleCnt + 5'd1;
    end
  end

  assign w_settled = (r_settleCnt == C_SETTLE);

  // Exactly-one-button detection and its index.
  always_comb begin
    w_oneHot = 1'b1;
    w_idx    = 2'd0;
    case (w_db)
      4'b0001: w_idx = 2'd0;
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_oneHot = 1'b0;
    endcase
  end

  // Next-state and next registered outputs; gameOver beats everything.
  always_comb begin
    w_nextState   = r_state;
    w_nextNum     = r_playerNum;
    w_nextPressed = 1'b0;
    if (gameOver) begin
      w_nextState = LOCKED;
    end else begin
      case (r_state)
        IDLE: begin
          if (!simonTurn && w_oneHot) begin
            w_nextState   = PRESSED;
            w_nextNum     = w_idx;
            w_nextPressed = 1'b1;
          end
        end
        PRESSED: begin
          if (simonTurn) begin
            w_nextState = WAIT_REL;
          end else if (!w_db[r_playerNum]) begin
            w_nextState = (w_db == 4'b0000) ? IDLE : WAIT_REL;
          end else begin
            w_nextPressed = 1'b1;
          end
        end
        WAIT_REL: begin
          if (w_settled && (w_db == 4'b0000)) begin
            w_nextState = IDLE;
          end
        end
        LOCKED:   w_nextState = LOCKED;
        default:  w_nextState = WAIT_REL;
      endcase
    end
  end

  // State and registered player outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= WAIT_REL;
      r_playerNum <= 2'd0;
      r_pressed   <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_playerNum <= w_nextNum;
      r_pressed   <= w_nextPressed;
    end
  end

`ifdef SIMON_PAD_GAMEOVER_BLINK_EN
  localparam logic [4:0] C_BLINK_LAST = 5'(BLINK_HALF - 1);

  logic [4:0] r_blinkCnt;
  logic       r_phase;

  // Blink timer runs only while locked; restarts dark on each entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blinkCnt <= 5'd0;
      r_phase    <= 1'b0;
    end else if (r_state != LOCKED) begin
      r_blinkCnt <= 5'd0;
      r_phase    <= 1'b0;
    end else if (r_blinkCnt == C_BLINK_LAST) begin
      r_blinkCnt <= 5'd0;
      r_phase    <= ~r_phase;
    end else begin
      r_blinkCnt <= r_blinkCnt + 5'd1;
    end
  end
`endif

  // LED drive: lockout pattern, else Simon's number, else player's press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led <= 4'b0000;
    end else if (r_state == LOCKED) begin
`ifdef SIMON_PAD_GAMEOVER_BLINK_EN
      r_led <= {4{r_phase}};
`else
      r_led <= 4'b1111;
`endif
    end else if (simonTurn) begin
      r_led <= simonPressed ? (4'b0001 << simonNum) : 4'b0000;
    end else begin
      r_led <= r_pressed ? (4'b0001 << r_playerNum) : 4'b0000;
    end
  end

  assign playerNum     = r_playerNum;
  assign playerPressed = r_pressed;
  assign led           = r_led;

endmodule
`default_nettype wire

// File: tb/tb_simon_pad.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_pad
// Purpose  : Self-checking bench for simon_pad against a behavioural model of
//            the panel rules (sample history, press/lock/release flags).
// Revision : 1.0 - initial release
// ============================================================================
module tb_simon_pad;

  localparam int DEB = 3;
  localparam int BH  = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       simonTurn;
  logic [1:0] simonNum;
  logic       simonPressed;
  logic       gameOver;
  logic [1:0] playerNum;
  logic       playerPressed;
  logic [3:0] led;

  int nCompared   = 0;
  int nMismatched = 0;

  simon_pad #(.DEBOUNCE_CYCLES(DEB), .BLINK_HALF(BH)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn          (btn),
    .simonTurn    (simonTurn),
    .simonNum     (simonNum),
    .simonPressed (simonPressed),
    .gameOver     (gameOver),
    .playerNum    (playerNum),
    .playerPressed(playerPressed),
    .led          (led)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [3:0] mSync1, mSync2, mDb, mLed;
  logic [3:0] sHist[$];
  bit         mLocked, mPressed, mWait;
  logic [1:0] mNum;
  int         mAge, mLockAge;

  task automatic checkEq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mSync1 = 4'h0; mSync2 = 4'h0; mDb = 4'h0; mLed = 4'h0;
    sHist.delete();
    mLocked = 0; mPressed = 0; mWait = 1; mNum = 2'd0;
    mAge = 0; mLockAge = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic modelStep();
    logic [3:0] nLed, nDb;
    bit diff;
    if (mLocked) begin
`ifdef SIMON_PAD_GAMEOVER_BLINK_EN
      nLed = (((mLockAge / BH) % 2) == 1) ? 4'hF : 4'h0;
      mLockAge++;
`else
      nLed = 4'hF;
`endif
    end else if (simonTurn) begin
      nLed = simonPressed ? (4'b0001 << simonNum) : 4'h0;
    end else begin
      nLed = mPressed ? (4'b0001 << mNum) : 4'h0;
    end

    if (gameOver || mLocked) begin
      if (!mLocked) mLockAge = 0;
      mLocked = 1; mPressed = 0; mWait = 0;
    end else if (mPressed) begin
      if (simonTurn) begin
        mPressed = 0; mWait = 1;
      end else if (!mDb[mNum]) begin
        mPressed = 0; mWait = (mDb != 4'h0);
      end
    end else if (mWait) begin
      if (mDb == 4'h0 && mAge >= DEB + 2) mWait = 0;
    end else if (!simonTurn && $countones(mDb) == 1) begin
      for (int i = 0; i < 4; i++) if (mDb[i]) mNum = 2'(i);
      mPressed = 1;
    end

    // A debounced level flips once the last DEB samples all disagree with it.
    sHist.push_back(mSync2);
    if (sHist.size() > DEB) void'(sHist.pop_front());
    nDb = mDb;
    if (sHist.size() == DEB) begin
      for (int b = 0; b < 4; b++) begin
        diff = 1;
        for (int j = 0; j < DEB; j++) if (sHist[j][b] == mDb[b]) diff = 0;
        if (diff) nDb[b] = ~mDb[b];
      end
    end
    mDb    = nDb;
    mSync2 = mSync1;
    mSync1 = btn;
    mLed   = nLed;
    mAge++;
  endtask

  task automatic compareAll(input string tag);
    checkEq({tag, ".pressed"}, 8'(playerPressed), 8'(mPressed));
    checkEq({tag, ".num"},     8'(playerNum),     8'(mNum));
    checkEq({tag, ".led"},     8'(led),           8'(mLed));
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    compareAll("cyc");
  endtask

  task automatic pulseReset();
    reset = 1'b0;
    #1;
    modelReset();
    compareAll("asyncRst");
    checkEq("asyncRst.direct", {2'b0, playerNum, playerPressed, 3'b0}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
  endtask

  int kind, len;

  initial begin
    reset = 1'b0; btn = 4'h0; simonTurn = 1'b0; simonNum = 2'd0;
    simonPressed = 1'b0; gameOver = 1'b0;
    modelReset();
    #12;
    compareAll("reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (8) tick();

    // Clean press of button 2 and its release.
    btn = 4'b0100;
    repeat (5) tick();
    checkEq("pressEarly", 8'(playerPressed), 8'd0);
    tick();
    checkEq("pressLat", 8'(playerPressed), 8'd1);
    checkEq("pressNum", 8'(playerNum), 8'd2);
    tick();
    checkEq("pressLed", 8'(led), 8'h04);
    btn = 4'b0000;
    repeat (5) tick();
    checkEq("relEarly", 8'(playerPressed), 8'd1);
    tick();
    checkEq("relLat", 8'(playerPressed), 8'd0);
    repeat (4) tick();

    // Bouncing button 1.
    for (int k = 0; k < 10; k++) begin
      btn[1] = ~btn[1];
      tick();
      checkEq("bounce", 8'(playerPressed), 8'd0);
    end
    btn[1] = 1'b1;
    repeat (5) tick();
    checkEq("bounceEarly", 8'(playerPressed), 8'd0);
    tick();
    checkEq("bouncePress", 8'(playerPressed), 8'd1);
    checkEq("bounceNum", 8'(playerNum), 8'd1);
    btn = 4'h0;
    repeat (8) tick();

    // Two buttons, then one released, then an extra button ignored.
    btn = 4'b0011;
    repeat (10) tick();
    checkEq("twoBtn", 8'(playerPressed), 8'd0);
    btn = 4'b0010;
    repeat (8) tick();
    checkEq("twoBtnRel", 8'(playerPressed), 8'd1);
    checkEq("twoBtnNum", 8'(playerNum), 8'd1);
    btn = 4'b1010;
    repeat (10) tick();
    checkEq("extraBtnNum", 8'(playerNum), 8'd1);
    checkEq("extraBtnHeld", 8'(playerPressed), 8'd1);
    btn = 4'h0;
    repeat (10) tick();

    // Simon's turn: LEDs follow Simon, buttons have no effect.
    simonTurn = 1'b1; simonNum = 2'd3;
    for (int k = 0; k < 18; k++) begin
      simonPressed = ((k / 3) % 2) == 1;
      btn = 4'($urandom);
      tick();
    end
    btn = 4'h0; simonPressed = 1'b1;
    repeat (8) tick();
    checkEq("simonLed", 8'(led), 8'h08);
    simonPressed = 1'b0; simonTurn = 1'b0;
    repeat (3) tick();

    // Button held from the player's turn across a whole Simon turn.
    btn = 4'b0001;
    repeat (7) tick();
    simonTurn = 1'b1;
    repeat (6) tick();
    checkEq("holdAcross", 8'(playerPressed), 8'd0);
    simonTurn = 1'b0;
    repeat (10) tick();
    checkEq("holdNoPress", 8'(playerPressed), 8'd0);
    btn = 4'h0;
    repeat (8) tick();
    btn = 4'b0001;
    repeat (6) tick();
    checkEq("repress", 8'(playerPressed), 8'd1);
    checkEq("repressNum", 8'(playerNum), 8'd0);

    // Reset mid-press with the button still held.
    btn = 4'b0100;
    repeat (8) tick();
    pulseReset();
    repeat (14) tick();
    checkEq("rstHeld", 8'(playerPressed), 8'd0);
    btn = 4'h0;
    repeat (8) tick();
    btn = 4'b0100;
    repeat (6) tick();
    checkEq("rstRepress", 8'(playerPressed), 8'd1);
    btn = 4'h0;
    repeat (8) tick();

    // Randomised traffic against the model.
    for (int seg = 0; seg < 250; seg++) begin
      kind = $urandom_range(0, 19);
      if (kind < 6)       btn = 4'h0;
      else if (kind < 14) btn = 4'b0001 << $urandom_range(0, 3);
      else if (kind < 19) btn = 4'($urandom);
      else                pulseReset();
      if ($urandom_range(0, 4) == 0) simonTurn = ~simonTurn;
      simonNum = 2'($urandom);
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        simonPressed = 1'($urandom);
        tick();
      end
    end

    // Game over during a press: lockout until reset.
    simonTurn = 1'b0; btn = 4'h0;
    repeat (10) tick();
    btn = 4'b1000;
    repeat (8) tick();
    checkEq("preLock", 8'(playerPressed), 8'd1);
    gameOver = 1'b1;
    tick();
    checkEq("lockDrop", 8'(playerPressed), 8'd0);
    gameOver = 1'b0;
    for (int k = 0; k < 45; k++) begin
      btn = 4'($urandom);
      simonTurn = 1'($urandom);
      tick();
      checkEq("lockedIgnore", 8'(playerPressed), 8'd0);
    end
    pulseReset();
    btn = 4'h0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
